commit_fence_sequencer: RTL
===========================

# commit_fence_sequencer

Sequences fence-class instructions (FENCE, FENCE.I, SFENCE.VMA) and external D$ flush requests at commit.
- Arbitrates between commit port 0 and the external flush requester.
- Waits for the store buffer to drain, then optionally flushes the D$ via handshake, then pulses I$/TLB/pipeline flushes.
- Signals completion so the commit stage can acknowledge the instruction.
- Sits between the commit stage, the LSU store buffer, the cache subsystem and the controller.

## Interface
Parameters:
- DCACHE_FLUSH_EN, 1, FENCE and FENCE.I write back/invalidate the D$ (0: write-through D$, skip).
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- halt_i  in  1  blocks acceptance of new requests.
- req_valid_i  in  1  commit port 0 holds a valid, exception-free fence-class op.
- req_kind_i  in  2  fence_kind_t: FK_FENCE=0, FK_FENCE_I=1, FK_SFENCE_VMA=2 (3 reserved, treated as FK_FENCE).
- req_done_o  out  1  one-cycle pulse: commit may ack port 0 this cycle.
- ext_flush_i  in  1  external D$ flush request, level, held until acked.
- ext_flush_ack_o  out  1  one-cycle pulse: external flush complete.
- no_st_pending_i  in  1  store buffer empty.
- flush_dcache_o  out  1  level D$ flush request.
- flush_dcache_ack_i  in  1  D$ flush complete (single-cycle).
- flush_icache_o  out  1  I$ invalidate pulse.
- flush_tlb_o  out  1  TLB flush pulse.
- flush_pipeline_o  out  1  pipeline flush pulse.
- busy_o  out  1  state != IDLE.
- stall_cnt_o  out  CNT_W  saturating count of cycles spent in DRAIN or DCACHE.
- cnt_clr_i  in  1  synchronous clear of stall_cnt_o.

## Operation
- States: IDLE, DRAIN, DCACHE, ACT.
- IDLE:
  - If !halt_i and req_valid_i: latch kind, owner=COMMIT, go to DRAIN.
  - Else if !halt_i and ext_flush_i: kind=FK_FENCE_I, owner=EXT, go to DRAIN.
  - Commit wins when both requests are present. The external request stays pending.
- DRAIN: wait for no_st_pending_i=1. Then:
  - Go to DCACHE if DCACHE_FLUSH_EN and kind ∈ {FENCE, FENCE_I}.
  - Otherwise go to ACT.
- DCACHE: flush_dcache_o=1. On flush_dcache_ack_i go to ACT.
- ACT: one cycle, then back to IDLE. Outputs this cycle:
  - flush_pipeline_o=1.
  - flush_icache_o=1 if kind=FENCE_I.
  - flush_tlb_o=1 if kind=SFENCE_VMA.
  - req_done_o=1 if owner=COMMIT, else ext_flush_ack_o=1.
- halt_i is sampled only in IDLE. An in-flight sequence always completes.
- req_valid_i and req_kind_i are ignored outside IDLE. The latched kind is used throughout the sequence.
- Stall counter:
  - Increments by 1 per cycle in DRAIN or DCACHE.
  - Saturates at 2^CNT_W-1.
  - cnt_clr_i has priority over increment.
- Reset (any time, including mid-sequence) forces IDLE, clears the latched kind/owner and clears the counter.

## Timing
- All outputs are 0 at reset. The counter resets to 0.
- All outputs are decoded from registered state. There is no combinational path from inputs to outputs, except flush_dcache_o, which depends on state only.
- Minimum latency, accept at cycle t with stores already drained and no D$ flush: DRAIN at t+1, ACT/done at t+2.
- With a D$ flush: flush_dcache_o rises at t+2. If the ack arrives at cycle a, ACT/done is at a+1.
- A new request can be accepted in the cycle after ACT.
  - The commit stage has already advanced its head by then, so there is no double trigger.
- An ack in the same cycle as the DRAIN→DCACHE transition is ignored. Acks are only honoured in DCACHE.
- Pulses are exactly one cycle wide.

## Structure
- Add fence_kind_t (2-bit enum) to ariane_pkg. It is shared with the commit stage, which derives req_kind_i from the op.
- The state enum stays local to this module.
- Single module. Natural optional sub-module: commit_stall_counter (saturating counter with clear), reusable for other perf events.

## Test plan
- FENCE, DCACHE_FLUSH_EN=0, no_st_pending_i=1: req at t → req_done_o and flush_pipeline_o at t+2. flush_dcache_o never set. stall_cnt_o=1.
- FENCE.I, DCACHE_FLUSH_EN=1, no_st_pending_i low for 5 cycles, ack 3 cycles after flush_dcache_o rises → flush_icache_o, flush_pipeline_o and req_done_o together in one cycle. stall_cnt_o=9.
- SFENCE.VMA with stores drained → flush_tlb_o pulse at t+2, flush_dcache_o=0, flush_icache_o=0.
- req_valid_i and ext_flush_i both set at t → commit sequence completes first. The ext sequence starts the cycle after ACT, and ext_flush_ack_o pulses without req_done_o.
- halt_i=1 in IDLE with req_valid_i → stays IDLE, busy_o=0. halt_i raised during DCACHE → sequence still completes on ack.
- rst_ni asserted while in DCACHE → all outputs 0 immediately. After release, a fresh FENCE completes normally. Counter saturates at 0xFFFF under a long ack stall and clears on cnt_clr_i.

Source files
------------

// File: rtl/commit_fence_sequencer_pkg.sv
// rtl/commit_fence_sequencer_pkg.sv - fence kind/owner types and decode helpers
package commit_fence_sequencer_pkg;

    typedef enum logic [1:0] {
        FK_FENCE      = 2'd0,
        FK_FENCE_I    = 2'd1,
        FK_SFENCE_VMA = 2'd2,
        FK_RSVD       = 2'd3
    } fence_kind_t;

    typedef enum logic {
        OWN_COMMIT = 1'b0,
        OWN_EXT    = 1'b1
    } fence_owner_t;

    // The reserved encoding behaves as a plain FENCE.
    function automatic fence_kind_t fence_kind_norm(input logic [1:0] raw);
        return (raw == 2'd3) ? FK_FENCE : fence_kind_t'(raw);
    endfunction

    function automatic logic fence_needs_dcache(input fence_kind_t kind);
        return (kind == FK_FENCE) || (kind == FK_FENCE_I);
    endfunction

endpackage

// File: rtl/commit_fence_sequencer_stall_counter.sv
// rtl/commit_fence_sequencer_stall_counter.sv - saturating event counter with synchronous clear
module commit_fence_sequencer_stall_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a simultaneous increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/commit_fence_sequencer.sv
// rtl/commit_fence_sequencer.sv - sequences fences and external D$ flushes at commit
module commit_fence_sequencer
    import commit_fence_sequencer_pkg::*;
#(
    parameter bit          DCACHE_FLUSH_EN = 1'b1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             halt_i,
    input  logic             req_valid_i,
    input  logic [1:0]       req_kind_i,
    output logic             req_done_o,
    input  logic             ext_flush_i,
    output logic             ext_flush_ack_o,
    input  logic             no_st_pending_i,
    output logic             flush_dcache_o,
    input  logic             flush_dcache_ack_i,
    output logic             flush_icache_o,
    output logic             flush_tlb_o,
    output logic             flush_pipeline_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    input  logic             cnt_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DCACHE = 2'd2,
        ST_ACT    = 2'd3
    } state_t;

    state_t       state_q, state_d;
    fence_kind_t  kind_q, kind_d;
    fence_owner_t owner_q, owner_d;
    logic         act;

    // Commit port takes priority; a held external request is picked up on a later IDLE.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!halt_i && req_valid_i) begin
                    kind_d  = fence_kind_norm(req_kind_i);
                    owner_d = OWN_COMMIT;
                    state_d = ST_DRAIN;
                end else if (!halt_i && ext_flush_i) begin
                    kind_d  = FK_FENCE_I;
                    owner_d = OWN_EXT;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (no_st_pending_i) begin
                    state_d = (DCACHE_FLUSH_EN && fence_needs_dcache(kind_q)) ? ST_DCACHE : ST_ACT;
                end
            end
            ST_DCACHE: begin
                if (flush_dcache_ack_i) begin
                    state_d = ST_ACT;
                end
            end
            ST_ACT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            kind_q  <= FK_FENCE;
            owner_q <= OWN_COMMIT;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            owner_q <= owner_d;
        end
    end

    assign act              = (state_q == ST_ACT);
    assign flush_dcache_o   = (state_q == ST_DCACHE);
    assign flush_pipeline_o = act;
    assign flush_icache_o   = act && (kind_q == FK_FENCE_I);
    assign flush_tlb_o      = act && (kind_q == FK_SFENCE_VMA);
    assign req_done_o       = act && (owner_q == OWN_COMMIT);
    assign ext_flush_ack_o  = act && (owner_q == OWN_EXT);
    assign busy_o           = (state_q != ST_IDLE);

    commit_fence_sequencer_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr_i),
        .inc_i  ((state_q == ST_DRAIN) || (state_q == ST_DCACHE)),
        .cnt_o  (stall_cnt_o)
    );

endmodule
